// File: rtl/tof_cnt_ctrl_if.sv
// tof_cnt_ctrl_if: result stream from the TOF window controller.
// Valid/ready handshake carrying one hit record per beat.
interface tof_cnt_ctrl_if #(
  parameter int CNT_W = 14,
  parameter int IDX_W = 2
);
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_data;
  logic [IDX_W-1:0] res_idx;
  logic             res_last;
  logic             res_timeout;

  modport master (
    output res_valid,
    output res_data,
    output res_idx,
    output res_last,
    output res_timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_idx,
    input  res_last,
    input  res_timeout,
    output res_ready
  );
endinterface

// File: rtl/tof_cnt_ctrl.sv
// tof_cnt_ctrl: TDC measurement window, hit capture and result drain.
// Optional macro TOF_CTRL_DEADTIME_EN adds a stop deadtime after each hit.
module tof_cnt_ctrl #(
  parameter int               CNT_W    = 14,
  parameter int               MAX_HITS = 4,
  parameter logic [CNT_W-1:0] TIMEOUT  = CNT_W'(16000),
  parameter int               DEADTIME = 8
) (
  input  logic             clk5,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             abort,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] counter_in,
  output logic             cnt_en,
  output logic             busy,
  tof_cnt_ctrl_if.master   res
);

  localparam int IDX_W = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1;
  localparam int HC_W  = $clog2(MAX_HITS + 1);
  localparam logic [HC_W-1:0] LAST_HC = HC_W'(MAX_HITS - 1);

  if (MAX_HITS < 2 || MAX_HITS > 8 || DEADTIME > 255) begin : g_bad_cfg
    $error("tof_cnt_ctrl: MAX_HITS or DEADTIME out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_base;
  logic [HC_W-1:0]  r_hcnt;
  logic [CNT_W-1:0] r_buf [MAX_HITS];
  logic             r_tmo;
  logic             r_cnt_en;
  logic             r_valid;
  logic [CNT_W-1:0] r_data;
  logic [IDX_W-1:0] r_idx;
  logic             r_last;
  logic             r_to;

  logic [CNT_W-1:0] w_elapsed;
  logic             w_run;
  logic             w_fire;
  logic             w_stop_ok;
  logic             w_hit;
  logic             w_tmo;
  logic             w_full;
  logic             w_done;
  logic             w_busy;
  logic             w_cnt_en_nxt;
  logic [IDX_W-1:0] w_ld_idx;
  logic [CNT_W-1:0] w_ld_data;
  logic             w_ld_last;
  logic             w_ld_to;

  // Elapsed time is modular so a counter wrap inside the window is harmless.
  assign w_elapsed = counter_in - r_base;
  assign w_run     = (r_state == S_RUN);
  assign w_fire    = (r_state == S_ARMED) & start;
  assign w_hit     = w_run & stop & w_stop_ok & ~abort;
  assign w_tmo     = w_run & (w_elapsed == TIMEOUT);
  assign w_full    = w_hit & (r_hcnt == LAST_HC);
  assign w_done    = r_valid & res.res_ready & r_last;

`ifdef TOF_CTRL_DEADTIME_EN
  localparam logic [7:0] DT_LD =
    8'((DEADTIME > 0) ? DEADTIME - 1 : 0);

  logic [7:0] r_dt;

  assign w_stop_ok = (r_dt == 8'd0);

  // Deadtime down-counter, reloaded on every accepted hit.
  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      r_dt <= 8'd0;
    end else if (abort || w_fire) begin
      r_dt <= 8'd0;
    end else if (w_hit) begin
      r_dt <= DT_LD;
    end else if (r_dt != 8'd0) begin
      r_dt <= r_dt - 8'd1;
    end
  end
`else
  assign w_stop_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort wins over everything.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (arm) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_full || w_tmo) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) w_state_nxt = S_IDLE;
  end

  // Output decode: busy flag and next counter enable.
  always_comb begin
    w_busy       = (r_state != S_IDLE);
    w_cnt_en_nxt = r_cnt_en;
    if (abort) begin
      w_cnt_en_nxt = 1'b0;
    end else if (w_fire) begin
      w_cnt_en_nxt = 1'b1;
    end else if (w_full || w_tmo) begin
      w_cnt_en_nxt = 1'b0;
    end
  end

  // Registered counter enable.
  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_en <= 1'b0;
    end else begin
      r_cnt_en <= w_cnt_en_nxt;
    end
  end

  // Window base, hit buffer, hit count and timeout flag.
  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      r_base <= '0;
      r_hcnt <= '0;
      r_tmo  <= 1'b0;
      for (int i = 0; i < MAX_HITS; i++) begin
        r_buf[i] <= '0;
      end
    end else if (abort || w_done) begin
      r_hcnt <= '0;
      r_tmo  <= 1'b0;
    end else begin
      if (w_fire) begin
        r_base <= counter_in;
        r_hcnt <= '0;
        r_tmo  <= 1'b0;
      end
      if (w_hit) begin
        r_buf[r_hcnt[IDX_W-1:0]] <= w_elapsed;
        r_hcnt <= r_hcnt + HC_W'(1);
      end
      if (w_tmo) begin
        r_tmo <= 1'b1;
      end
    end
  end

  // Next record to present: first one on entry, else the following one.
  always_comb begin
    w_ld_idx  = r_valid ? r_idx + IDX_W'(1) : '0;
    w_ld_data = r_buf[w_ld_idx];
    w_ld_last = (HC_W'(w_ld_idx) == r_hcnt - HC_W'(1));
    w_ld_to   = r_tmo;
    if (r_hcnt == '0) begin
      w_ld_data = TIMEOUT;
      w_ld_last = 1'b1;
      w_ld_to   = 1'b1;
    end
  end

  // Result stream register; fields only move on accept.
  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_to    <= 1'b0;
    end else if (abort || w_done) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_to    <= 1'b0;
    end else if (r_state == S_DRAIN &&
                 (!r_valid || res.res_ready)) begin
      r_valid <= 1'b1;
      r_data  <= w_ld_data;
      r_idx   <= w_ld_idx;
      r_last  <= w_ld_last;
      r_to    <= w_ld_to;
    end
  end

  assign cnt_en          = r_cnt_en;
  assign busy            = w_busy;
  assign res.res_valid   = r_valid;
  assign res.res_data    = r_data;
  assign res.res_idx     = r_idx;
  assign res.res_last    = r_last;
  assign res.res_timeout = r_to;

endmodule

// File: tb/tb_tof_cnt_ctrl.sv
// tb_tof_cnt_ctrl: randomized scenario bench for tof_cnt_ctrl.
// Build with or without TOF_CTRL_DEADTIME_EN to match the DUT.
module tb_tof_cnt_ctrl;

  localparam int CW  = 14;
  localparam int MH  = 4;
  localparam int IW  = 2;
  localparam int TMO = 400;
  localparam int DT  = 8;
  localparam int RW  = CW + IW + 2;

  logic          clk5   = 1'b0;
  logic          rst_n  = 1'b0;
  logic          arm    = 1'b0;
  logic          abort  = 1'b0;
  logic          start  = 1'b0;
  logic          stop   = 1'b0;
  logic          ld     = 1'b0;
  logic [CW-1:0] ld_val = '0;
  logic [CW-1:0] cnt;
  logic          cnt_en;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  tof_cnt_ctrl_if #(.CNT_W(CW), .IDX_W(IW)) rif ();

  tof_cnt_ctrl #(
    .CNT_W    (CW),
    .MAX_HITS (MH),
    .TIMEOUT  (CW'(TMO)),
    .DEADTIME (DT)
  ) u_dut (
    .clk5       (clk5),
    .rst_n      (rst_n),
    .arm        (arm),
    .abort      (abort),
    .start      (start),
    .stop       (stop),
    .counter_in (cnt),
    .cnt_en     (cnt_en),
    .busy       (busy),
    .res        (rif)
  );

  always #5 clk5 = ~clk5;

  // Free-running fine counter with a preload port and no clear.
  always @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (ld) cnt <= ld_val;
    else if (cnt_en) cnt <= cnt + CW'(1);
  end

  bit              g_map [0:511];
  int              e_exit, e_n;
  logic [MH*RW-1:0] e_rec;
  int              o_exit, o_n, o_hold_err;
  bit              o_en_ok, o_v0, o_v1, o_busy_after, o_tout;
  logic [MH*RW-1:0] o_rec;

  task automatic clear_map;
    foreach (g_map[i]) g_map[i] = 1'b0;
  endtask

  // Reference: walk stop times after start, keep the ones the window takes.
  task automatic model;
    int ed [MH];
    int n;
    bit tmo;
`ifdef TOF_CTRL_DEADTIME_EN
    int last;
    last = -100000;
`endif
    n = 0;
    tmo = 1'b1;
    e_exit = TMO + 1;
    e_rec = '0;
    for (int k = 1; k <= TMO + 1; k++) begin
      if (!g_map[k]) continue;
`ifdef TOF_CTRL_DEADTIME_EN
      if (k - last < DT) continue;
      last = k;
`endif
      ed[n] = k - 1;
      n++;
      if (n == MH) begin
        e_exit = k;
        tmo = (k == TMO + 1);
        break;
      end
    end
    if (n == 0) begin
      e_n = 1;
      e_rec[RW-1:0] = {CW'(TMO), IW'(0), 1'b1, 1'b1};
    end else begin
      e_n = n;
      for (int i = 0; i < n; i++)
        e_rec[i*RW +: RW] = {CW'(ed[i]), IW'(i), (i == n - 1), tmo};
    end
  endtask

  // Preload counter, arm, fire start, replay the stop map.
  task automatic drive_window(input logic [CW-1:0] pre);
    @(negedge clk5);
    ld = 1'b1; ld_val = pre; stop = 1'b1;
    @(negedge clk5);
    ld = 1'b0; stop = 1'b0; arm = 1'b1;
    @(negedge clk5);
    start = 1'b1; stop = g_map[0];
    @(negedge clk5);
    arm = 1'b0; start = 1'b0;
    o_en_ok = (cnt_en === 1'b1) && (busy === 1'b1) && (cnt === pre);
    o_exit = -1;
    for (int k = 1; k <= TMO + 5; k++) begin
      stop = g_map[k];
      @(negedge clk5);
      if (cnt_en !== 1'b1) begin
        o_exit = k;
        break;
      end
    end
    stop = 1'b0;
    o_v0 = rif.res_valid;
    @(negedge clk5);
    o_v1 = rif.res_valid;
  endtask

  // Accept records under a ready pattern: 0 always, 1 random, 2 stall 10.
  task automatic drain(input int rmode);
    bit done, hold, r;
    logic [RW:0] saved;
    done = 0; hold = 0; saved = '0;
    o_n = 0; o_hold_err = 0; o_rec = '0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (hold && {rif.res_valid, rif.res_data, rif.res_idx,
                   rif.res_last, rif.res_timeout} !== saved)
        o_hold_err++;
      if (rmode == 0) r = 1'b1;
      else if (rmode == 1) r = 1'($urandom_range(0, 1));
      else r = (c >= 10);
      rif.res_ready = r;
      if (rif.res_valid === 1'b1 && r) begin
        if (o_n < MH)
          o_rec[o_n*RW +: RW] = {rif.res_data, rif.res_idx,
                                 rif.res_last, rif.res_timeout};
        o_n++;
        if (rif.res_last === 1'b1) done = 1;
      end
      hold = (rif.res_valid === 1'b1) && !r;
      saved = {rif.res_valid, rif.res_data, rif.res_idx,
               rif.res_last, rif.res_timeout};
      @(negedge clk5);
    end
    rif.res_ready = 1'b0;
    o_tout = !done;
    o_busy_after = busy | rif.res_valid;
  endtask

  task automatic run(input logic [CW-1:0] pre, input int rmode);
    model();
    drive_window(pre);
    drain(rmode);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk5);
    checks++;
    if ({cnt_en, busy, rif.res_valid, rif.res_data, rif.res_idx,
         rif.res_last, rif.res_timeout} !== '0) begin
      failures++;
      $display("FAIL reset_in: cnt_en=%0b busy=%0b valid=%0b data=%h, want all 0",
               cnt_en, busy, rif.res_valid, rif.res_data);
    end
    rst_n = 1'b1;
    @(negedge clk5);
    checks++;
    if ({cnt_en, busy, rif.res_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_out: cnt_en=%0b busy=%0b valid=%0b, want 000",
               cnt_en, busy, rif.res_valid);
    end
  endtask

  task automatic test_basic;
    clear_map(); g_map[5] = 1; g_map[20] = 1; g_map[300] = 1;
    run(CW'($urandom), 0);
    checks++;
    if (o_exit != e_exit || !o_en_ok || o_v0 || !o_v1 || o_busy_after) begin
      failures++;
      $display("FAIL basic_timing: exit=%0d en=%0b v=%0b%0b busy=%0b, want exit=%0d en=1 v=01 busy=0",
               o_exit, o_en_ok, o_v0, o_v1, o_busy_after, e_exit);
    end
    checks++;
    if (o_n != e_n || o_rec !== e_rec || o_tout) begin
      failures++;
      $display("FAIL basic_rec: n=%0d rec=%h, want n=%0d rec=%h",
               o_n, o_rec, e_n, e_rec);
    end
  endtask

  task automatic test_full;
    clear_map();
    g_map[10] = 1; g_map[20] = 1; g_map[30] = 1; g_map[40] = 1; g_map[50] = 1;
    run(CW'($urandom), 0);
    checks++;
    if (o_exit != e_exit || !o_en_ok || o_v0 || !o_v1 || o_busy_after) begin
      failures++;
      $display("FAIL full_timing: exit=%0d en=%0b v=%0b%0b busy=%0b, want exit=%0d en=1 v=01 busy=0",
               o_exit, o_en_ok, o_v0, o_v1, o_busy_after, e_exit);
    end
    checks++;
    if (o_n != e_n || o_rec !== e_rec || o_tout) begin
      failures++;
      $display("FAIL full_rec: n=%0d rec=%h, want n=%0d rec=%h",
               o_n, o_rec, e_n, e_rec);
    end
  endtask

  task automatic test_no_hits;
    clear_map();
    g_map[TMO + 2] = 1;
    run(CW'($urandom), 0);
    checks++;
    if (o_exit != TMO + 1 || o_v0 || !o_v1 || o_busy_after) begin
      failures++;
      $display("FAIL nohit_timing: exit=%0d v=%0b%0b busy=%0b, want exit=%0d v=01 busy=0",
               o_exit, o_v0, o_v1, o_busy_after, TMO + 1);
    end
    checks++;
    if (o_n != e_n || o_rec !== e_rec || o_tout) begin
      failures++;
      $display("FAIL nohit_rec: n=%0d rec=%h, want n=%0d rec=%h",
               o_n, o_rec, e_n, e_rec);
    end
  endtask

  task automatic test_tmo_edge;
    clear_map();
    g_map[100] = 1; g_map[200] = 1; g_map[300] = 1; g_map[TMO + 1] = 1;
    run(CW'($urandom), 0);
    checks++;
    if (o_exit != e_exit || o_n != e_n || o_rec !== e_rec || o_tout) begin
      failures++;
      $display("FAIL tmo_edge: exit=%0d n=%0d rec=%h, want exit=%0d n=%0d rec=%h",
               o_exit, o_n, o_rec, e_exit, e_n, e_rec);
    end
  endtask

  task automatic test_wrap;
    clear_map(); g_map[40] = 1;
    run(14'h3FF0, 0);
    checks++;
    if (o_exit != e_exit || o_n != e_n || o_rec !== e_rec || o_tout) begin
      failures++;
      $display("FAIL wrap: exit=%0d n=%0d rec=%h, want exit=%0d n=%0d rec=%h",
               o_exit, o_n, o_rec, e_exit, e_n, e_rec);
    end
  endtask

  task automatic test_backpressure;
    clear_map(); g_map[3] = 1; g_map[4] = 1; g_map[5] = 1;
    run(CW'($urandom), 2);
    checks++;
    if (o_hold_err != 0) begin
      failures++;
      $display("FAIL bp_hold: unstable_cycles=%0d, want 0", o_hold_err);
    end
    checks++;
    if (o_n != e_n || o_rec !== e_rec || o_tout || o_busy_after) begin
      failures++;
      $display("FAIL bp_rec: n=%0d rec=%h busy=%0b, want n=%0d rec=%h busy=0",
               o_n, o_rec, o_busy_after, e_n, e_rec);
    end
  endtask

  task automatic test_abort;
    logic [CW-1:0] held;
    bit v_seen;
    @(negedge clk5); arm = 1'b1;
    @(negedge clk5); arm = 1'b0; start = 1'b1;
    @(negedge clk5); start = 1'b0;
    for (int k = 1; k < 30; k++) begin
      stop = (k == 5 || k == 20);
      @(negedge clk5);
    end
    stop = 1'b0; abort = 1'b1;
    @(negedge clk5);
    abort = 1'b0;
    held = cnt;
    checks++;
    if ({cnt_en, busy, rif.res_valid} !== 3'b000) begin
      failures++;
      $display("FAIL abort_now: cnt_en=%0b busy=%0b valid=%0b, want 000",
               cnt_en, busy, rif.res_valid);
    end
    v_seen = 0;
    rif.res_ready = 1'b1;
    repeat (8) begin
      @(negedge clk5);
      if (rif.res_valid !== 1'b0 || busy !== 1'b0) v_seen = 1;
    end
    rif.res_ready = 1'b0;
    checks++;
    if (v_seen || cnt !== held) begin
      failures++;
      $display("FAIL abort_after: active=%0b cnt=%h, want active=0 cnt=%h",
               v_seen, cnt, held);
    end
  endtask

  task automatic test_deadtime;
    int want_n;
`ifdef TOF_CTRL_DEADTIME_EN
    want_n = 2;
`else
    want_n = 3;
`endif
    clear_map(); g_map[10] = 1; g_map[12] = 1; g_map[18] = 1;
    run(CW'($urandom), 0);
    checks++;
    if (o_n != want_n || o_n != e_n || o_rec !== e_rec || o_tout) begin
      failures++;
      $display("FAIL deadtime: n=%0d rec=%h, want n=%0d rec=%h",
               o_n, o_rec, want_n, e_rec);
    end
  endtask

  task automatic test_back_to_back;
    clear_map();
    g_map[0] = 1; g_map[1] = 1; g_map[2] = 1; g_map[3] = 1; g_map[4] = 1;
    run(CW'($urandom), 1);
    checks++;
    if (o_exit != e_exit || o_n != e_n || o_rec !== e_rec || o_tout ||
        o_hold_err != 0) begin
      failures++;
      $display("FAIL b2b: exit=%0d n=%0d rec=%h hold=%0d, want exit=%0d n=%0d rec=%h hold=0",
               o_exit, o_n, o_rec, o_hold_err, e_exit, e_n, e_rec);
    end
  endtask

  task automatic test_random;
    int n, b;
    for (int it = 0; it < 8; it++) begin
      clear_map();
      n = $urandom_range(0, 6);
      b = $urandom_range(1, 300);
      for (int j = 0; j < n; j++) begin
        if (it % 2 == 0) g_map[$urandom_range(0, TMO + 10)] = 1;
        else g_map[b + $urandom_range(0, 12)] = 1;
      end
      run(CW'($urandom), $urandom_range(0, 1));
      checks++;
      if (o_exit != e_exit || !o_en_ok || o_v0 || !o_v1 ||
          o_busy_after) begin
        failures++;
        $display("FAIL rand%0d_timing: exit=%0d en=%0b v=%0b%0b busy=%0b, want exit=%0d en=1 v=01 busy=0",
                 it, o_exit, o_en_ok, o_v0, o_v1, o_busy_after, e_exit);
      end
      checks++;
      if (o_n != e_n || o_rec !== e_rec || o_tout || o_hold_err != 0) begin
        failures++;
        $display("FAIL rand%0d_rec: n=%0d rec=%h hold=%0d, want n=%0d rec=%h hold=0",
                 it, o_n, o_rec, o_hold_err, e_n, e_rec);
      end
    end
  endtask

  initial begin
    rif.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_full();
    test_no_hits();
    test_tmo_edge();
    test_wrap();
    test_backpressure();
    test_abort();
    test_full();
    test_deadtime();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
